// File: rtl/vernier_pkg.sv
// Shared constants, FSM states and the Vernier forward map used by both
// the point map and the inverse seek, so the two directions cannot diverge.
package vernier_pkg;

  localparam int unsigned T_MIN          = 2;
  localparam int unsigned T_MAX          = 120;
  localparam int unsigned VERNIER_PERIOD = 5;
  localparam int unsigned VERNIER_PHASE  = 3;
  localparam int unsigned COARSE_STEP    = 80;
  localparam int unsigned COARSE_OFS     = 10;
  localparam int unsigned FINE_STEP      = 16;
  localparam int unsigned FINE_OFS       = 2;
  localparam int unsigned MAP_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest mapped offset is 80*120+10 = 9610, so 16 bits always suffice.
  function automatic logic [MAP_W-1:0] vernier_map(input logic [7:0] t);
    logic [MAP_W-1:0] t_w;
    t_w = {8'd0, t};
    if ((t_w % MAP_W'(VERNIER_PERIOD)) == MAP_W'(VERNIER_PHASE)) begin
      vernier_map = t_w * MAP_W'(FINE_STEP) + MAP_W'(FINE_OFS);
    end else begin
      vernier_map = t_w * MAP_W'(COARSE_STEP) + MAP_W'(COARSE_OFS);
    end
  endfunction

endpackage

// File: rtl/vernier_pt_cand.sv
// Combinational candidate evaluator: mapped offset of one step code and its
// unsigned absolute distance from the target.
module vernier_pt_cand
  import vernier_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [7:0]   idx,
  input  logic [W-1:0] target,
  output logic [W-1:0] map_ps,
  output logic [W-1:0] err_ps
);

  logic [W-1:0] map_s;

  // Compare first so the subtraction can never wrap.
  always_comb begin
    map_s = {{(W-MAP_W){1'b0}}, vernier_map(idx)};
    if (map_s >= target) begin
      err_ps = map_s - target;
    end else begin
      err_ps = target - map_s;
    end
  end

  assign map_ps = map_s;

endmodule

// File: rtl/vernier_pt_seek.sv
// Inverse Vernier point map: scans every valid step code, one per clock, and
// returns the code whose mapped offset is closest to the requested offset.
module vernier_pt_seek
  import vernier_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] target_ps,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   t_code,
  output logic [W-1:0] avg_ps,
  output logic [W-1:0] err_ps
);

  state_t       state_r;
  state_t       state_s;
  logic         accept_s;
  logic         better_s;
  logic [7:0]   idx_r;
  logic [W-1:0] target_r;
  logic [W-1:0] best_err_r;
  logic [W-1:0] best_avg_r;
  logic [7:0]   best_t_r;
  logic [W-1:0] cand_map_s;
  logic [W-1:0] cand_err_s;

  vernier_pt_cand #(.W(W)) u_cand (
    .idx    (idx_r),
    .target (target_r),
    .map_ps (cand_map_s),
    .err_ps (cand_err_s)
  );

  // Strict compare keeps the lowest code on ties.
  assign better_s = (cand_err_s < best_err_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_s = 1'b1;
          state_s  = SCAN;
        end else begin
          state_s  = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == 8'(T_MAX)) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Scan datapath, best-candidate tracking and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r      <= 8'd0;
      target_r   <= '0;
      best_err_r <= '0;
      best_avg_r <= '0;
      best_t_r   <= 8'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      t_code     <= 8'd0;
      avg_ps     <= '0;
      err_ps     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            target_r   <= target_ps;
            idx_r      <= 8'(T_MIN);
            best_err_r <= '1;
            in_ready   <= 1'b0;
          end
        end
        SCAN: begin
          if (better_s) begin
            best_err_r <= cand_err_s;
            best_avg_r <= cand_map_s;
            best_t_r   <= idx_r;
          end
          if (idx_r != 8'(T_MAX)) begin
            idx_r <= idx_r + 8'd1;
          end
        end
        // First DONE cycle publishes the settled best; then wait for the consumer.
        DONE: begin
          if (!out_valid) begin
            t_code    <= best_t_r;
            avg_ps    <= best_avg_r;
            err_ps    <= best_err_r;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vernier_pt_seek.sv
// Self-checking bench for vernier_pt_seek: directed and random targets against
// a brute-force nearest-point model, plus latency, backpressure and reset.
module tb_vernier_pt_seek;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] target_ps;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  t_code;
  logic [31:0] avg_ps;
  logic [31:0] err_ps;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vernier_pt_seek #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .target_ps (target_ps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .t_code    (t_code),
    .avg_ps    (avg_ps),
    .err_ps    (err_ps)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Nearest mapped point over all valid codes; first minimum wins.
  task automatic model(input longint tgt, output longint bt, output longint ba, output longint be);
    longint m;
    longint e;
    be = -1;
    bt = 0;
    ba = 0;
    for (int k = 2; k <= 120; k++) begin
      m = (k % 5 == 3) ? (16 * k + 2) : (80 * k + 10);
      e = (m > tgt) ? (m - tgt) : (tgt - m);
      if (be < 0 || e < be) begin
        be = e;
        bt = k;
        ba = m;
      end
    end
  endtask

  task automatic run_req(input logic [31:0] tgt, input bit noise, input int hold);
    int n;
    longint et, ea, ee;
    model({32'd0, tgt}, et, ea, ee);
    chk("in_ready_before", in_ready, 1);
    in_valid  = 1'b1;
    target_ps = tgt;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    target_ps = $urandom;
    n = 0;
    while (!out_valid && n < 200) begin
      if (noise) in_valid = (n < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, 120);
    chk("in_ready_busy", in_ready, 0);
    chk("t_code", t_code, et);
    chk("avg_ps", avg_ps, ea);
    chk("err_ps", err_ps, ee);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (h == hold - 1) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_t_code", t_code, et);
        chk("hold_avg", avg_ps, ea);
        chk("hold_err", err_ps, ee);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    target_ps = 32'd0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_t_code", t_code, 0);
    chk("rst_avg", avg_ps, 0);
    chk("rst_err", err_ps, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(32'd50, 1'b0, 0);
    run_req(32'd150, 1'b0, 0);
    run_req(32'd100, 1'b1, 0);
    run_req(32'd0, 1'b0, 0);
    run_req(32'd20000, 1'b0, 50);
    run_req(32'hFFFF_FFFF, 1'b0, 0);

    // Reset in the middle of a scan discards the pending result.
    in_valid  = 1'b1;
    target_ps = 32'd777;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_t_code", t_code, 0);
    chk("midrst_avg", avg_ps, 0);
    chk("midrst_err", err_ps, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_req(32'd9530, 1'b0, 0);

    for (int r = 0; r < 10; r++) begin
      if (r < 7) run_req(32'($urandom_range(0, 10000)), r[0], r % 3);
      else run_req($urandom, 1'b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
